// File: rtl/relu_burst_scheduler.sv
// relu_burst_scheduler
//
// Shares one pipelined element-wise activation unit among NUM_REQ vector
// producers. Whole bursts of VEC_LEN elements are granted round-robin and
// streamed into the unit one element per cycle. A tag pipeline of the same
// depth as the unit follows each element, so every result can be labelled
// with its requester ID and an end-of-vector flag when it comes out.
//
// Ports:
//   clk            single clock, all logic on the rising edge
//   rst_n          asynchronous active-low reset
//   req_valid      per-requester "element present on my lane"
//   req_data       flattened lanes, lane i = [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready      per-requester "your element was consumed this cycle"
//   act_valid_in   element valid towards the activation unit
//   act_data_in    element data towards the activation unit
//   act_valid_out  result valid from the activation unit
//   act_data_out   result data from the activation unit
//   out_valid      tagged result valid
//   out_data       tagged result data
//   out_id         requester that owns the result
//   out_last       result is the final element of its burst
//   busy           a burst is open or results are still in flight
//   tag_err        sticky: a result arrived that nothing was issued for

module relu_burst_scheduler #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int VEC_LEN     = 16,
    parameter int ACT_LATENCY = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          act_valid_in,
    output logic [DATA_WIDTH-1:0]         act_data_in,
    input  logic                          act_valid_out,
    input  logic [DATA_WIDTH-1:0]         act_data_out,
    output logic                          out_valid,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic [$clog2(NUM_REQ)-1:0]    out_id,
    output logic                          out_last,
    output logic                          busy,
    output logic                          tag_err
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = $clog2(VEC_LEN);

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [IDW-1:0]   owner;
    logic [IDW-1:0]   next_owner;
    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   next_rr_ptr;
    logic [CW-1:0]    beat_cnt;
    logic [CW-1:0]    next_beat_cnt;

    logic             any_req;
    logic [IDW-1:0]   winner;
    logic [IDW:0]     cand;
    logic             fire;
    logic             last_beat;

    logic [ACT_LATENCY-1:0] tag_v;
    logic [ACT_LATENCY-1:0] tag_last;
    logic [IDW-1:0]         tag_id [ACT_LATENCY];

    // Round-robin search starting at rr_ptr. The loop walks offsets from
    // the far end back to rr_ptr so the nearest asserted requester is the
    // last one written and therefore wins. cand is one bit wider so the
    // wrap works for NUM_REQ that is not a power of two.
    always_comb begin
        any_req = 1'b0;
        winner  = '0;
        cand    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = {1'b0, rr_ptr} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(NUM_REQ)) begin
                cand = cand - (IDW+1)'(NUM_REQ);
            end
            if (req_valid[cand[IDW-1:0]]) begin
                any_req = 1'b1;
                winner  = cand[IDW-1:0];
            end
        end
    end

    // Issue path and next-state logic. Only the owner's lane is ever looked
    // at during a burst; a stalled owner simply freezes the burst in place.
    always_comb begin
        fire          = (state == BURST) && req_valid[owner];
        last_beat     = (beat_cnt == CW'(VEC_LEN - 1));
        req_ready     = '0;
        if (fire) begin
            req_ready[owner] = 1'b1;
        end
        act_valid_in  = fire;
        act_data_in   = req_data[owner*DATA_WIDTH +: DATA_WIDTH];

        next_state    = state;
        next_owner    = owner;
        next_beat_cnt = beat_cnt;
        next_rr_ptr   = rr_ptr;

        case (state)
            IDLE: begin
                if (any_req) begin
                    next_owner    = winner;
                    next_beat_cnt = '0;
                    next_state    = BURST;
                end
            end
            BURST: begin
                if (fire) begin
                    if (last_beat) begin
                        // The requester just served drops to lowest priority.
                        next_rr_ptr   = (owner == IDW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
                        next_beat_cnt = '0;
                        next_state    = IDLE;
                    end else begin
                        next_beat_cnt = beat_cnt + 1'b1;
                    end
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            owner    <= '0;
            beat_cnt <= '0;
            rr_ptr   <= '0;
        end else begin
            state    <= next_state;
            owner    <= next_owner;
            beat_cnt <= next_beat_cnt;
            rr_ptr   <= next_rr_ptr;
        end
    end

    // Tag pipeline shadowing the activation unit. Stage 0 captures what was
    // issued this cycle; the last stage lines up with act_valid_out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_v    <= '0;
            tag_last <= '0;
            for (int k = 0; k < ACT_LATENCY; k++) begin
                tag_id[k] <= '0;
            end
        end else begin
            tag_v[0]    <= fire;
            tag_id[0]   <= owner;
            tag_last[0] <= fire & last_beat;
            for (int k = 1; k < ACT_LATENCY; k++) begin
                tag_v[k]    <= tag_v[k-1];
                tag_id[k]   <= tag_id[k-1];
                tag_last[k] <= tag_last[k-1];
            end
        end
    end

    // A result with no matching tag means the unit's latency does not match
    // ACT_LATENCY or it produced a spurious output; latch it until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_err <= 1'b0;
        end else if (act_valid_out && !tag_v[ACT_LATENCY-1]) begin
            tag_err <= 1'b1;
        end
    end

    assign out_valid = act_valid_out;
    assign out_data  = act_data_out;
    assign out_id    = tag_id[ACT_LATENCY-1];
    assign out_last  = tag_last[ACT_LATENCY-1];
    assign busy      = (state == BURST) | (|tag_v);

endmodule

// File: tb/tb_relu_burst_scheduler.sv
// tb_relu_burst_scheduler
//
// Directed self-checking bench for relu_burst_scheduler. Two instances share
// the requester inputs: one with a 1-cycle activation unit, one with a
// 3-cycle unit. Each has its own behavioural ReLU pipeline. Inputs are driven
// on the falling edge and outputs sampled 2 time units later.

module tb_relu_burst_scheduler;

    localparam int NR = 4;
    localparam int DW = 32;
    localparam int VL = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NR-1:0] req_valid;
    logic [NR*DW-1:0] req_data;
    logic          inject;

    logic [NR-1:0] req_ready;
    logic          act_valid_in;
    logic [DW-1:0] act_data_in;
    logic          act_valid_out;
    logic [DW-1:0] act_data_out;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [1:0]    out_id;
    logic          out_last;
    logic          busy;
    logic          tag_err;

    logic [NR-1:0] rdy3;
    logic          avi3;
    logic [DW-1:0] adi3;
    logic          avo3;
    logic [DW-1:0] ado3;
    logic          ov3;
    logic [DW-1:0] od3;
    logic [1:0]    oid3;
    logic          ol3;
    logic          busy3;
    logic          terr3;

    logic          r1_v;
    logic [DW-1:0] r1_d;
    logic [2:0]    p3_v;
    logic [DW-1:0] p3_d [3];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    relu_burst_scheduler #(
        .NUM_REQ(NR), .DATA_WIDTH(DW), .VEC_LEN(VL), .ACT_LATENCY(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .act_valid_in(act_valid_in), .act_data_in(act_data_in),
        .act_valid_out(act_valid_out), .act_data_out(act_data_out),
        .out_valid(out_valid), .out_data(out_data), .out_id(out_id),
        .out_last(out_last), .busy(busy), .tag_err(tag_err)
    );

    relu_burst_scheduler #(
        .NUM_REQ(NR), .DATA_WIDTH(DW), .VEC_LEN(VL), .ACT_LATENCY(3)
    ) dut3 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(rdy3), .act_valid_in(avi3), .act_data_in(adi3),
        .act_valid_out(avo3), .act_data_out(ado3),
        .out_valid(ov3), .out_data(od3), .out_id(oid3),
        .out_last(ol3), .busy(busy3), .tag_err(terr3)
    );

    function automatic logic [DW-1:0] relu(input logic [DW-1:0] x);
        return x[DW-1] ? '0 : x;
    endfunction

    // 1-cycle ReLU unit for the first instance; inject forces a spurious
    // result so the tag error path can be exercised.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r1_v <= 1'b0;
            r1_d <= '0;
        end else begin
            r1_v <= act_valid_in;
            r1_d <= relu(act_data_in);
        end
    end
    assign act_valid_out = r1_v | inject;
    assign act_data_out  = r1_d;

    // 3-cycle ReLU unit for the second instance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p3_v    <= '0;
            p3_d[0] <= '0;
            p3_d[1] <= '0;
            p3_d[2] <= '0;
        end else begin
            p3_v    <= {p3_v[1:0], avi3};
            p3_d[0] <= relu(adi3);
            p3_d[1] <= p3_d[0];
            p3_d[2] <= p3_d[1];
        end
    end
    assign avo3 = p3_v[2];
    assign ado3 = p3_d[2];

    task automatic set_lane(input int i, input logic [DW-1:0] v);
        req_data[i*DW +: DW] = v;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = '0;
        inject    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Reset state, with every requester asserting to prove nothing leaks.
    task automatic test_reset();
        @(negedge clk);
        req_valid = '1;
        #2;
        checks++;
        if ({req_ready, act_valid_in, busy, tag_err, out_id, out_last} !== 10'b0) begin
            failures++;
            $display("[TB] FAIL reset_outputs: got %b expected 0",
                     {req_ready, act_valid_in, busy, tag_err, out_id, out_last});
        end
        @(negedge clk);
        rst_n     = 1'b1;
        req_valid = '0;
    endtask

    // One full burst from requester 2 with lane data 100..115.
    task automatic test_single_burst();
        @(negedge clk);
        req_valid = 4'b0100;
        set_lane(2, 32'd100);
        #2;
        checks++;
        if ({req_ready, act_valid_in} !== 5'b0) begin
            failures++;
            $display("[TB] FAIL single_grant_cycle: got %b expected 0", {req_ready, act_valid_in});
        end
        for (int b = 0; b < VL; b++) begin
            @(negedge clk);
            set_lane(2, 32'(100 + b));
            #2;
            checks++;
            if ({req_ready, act_valid_in, act_data_in} !== {4'b0100, 1'b1, 32'(100 + b)}) begin
                failures++;
                $display("[TB] FAIL single_issue%0d: got %b/%b/%0d expected 0100/1/%0d",
                         b, req_ready, act_valid_in, act_data_in, 100 + b);
            end
            if (b > 0) begin
                checks++;
                if ({out_valid, out_id, out_last, out_data} !== {1'b1, 2'd2, 1'b0, 32'(99 + b)}) begin
                    failures++;
                    $display("[TB] FAIL single_out%0d: got v=%b id=%0d last=%b d=%0d expected 1/2/0/%0d",
                             b - 1, out_valid, out_id, out_last, out_data, 99 + b);
                end
            end
        end
        @(negedge clk);
        req_valid = '0;
        #2;
        checks++;
        if ({out_valid, out_id, out_last, out_data, busy, act_valid_in} !==
            {1'b1, 2'd2, 1'b1, 32'd115, 1'b1, 1'b0}) begin
            failures++;
            $display("[TB] FAIL single_last: got v=%b id=%0d last=%b d=%0d busy=%b avi=%b expected 1/2/1/115/1/0",
                     out_valid, out_id, out_last, out_data, busy, act_valid_in);
        end
        @(negedge clk);
        #2;
        checks++;
        if ({out_valid, busy} !== 2'b00) begin
            failures++;
            $display("[TB] FAIL single_drain: got v=%b busy=%b expected 0/0", out_valid, busy);
        end
    endtask

    // Requesters 0 and 3 alternate; requester 1 joins during the 4th burst.
    task automatic test_round_robin();
        int exp_order [7] = '{0, 3, 0, 3, 0, 1, 3};
        int nburst  = 0;
        int issued  = 0;
        int gaps    = 0;
        bit started = 1'b0;
        do_reset();
        for (int i = 0; i < NR; i++) set_lane(i, 32'(10 * i + 1));
        for (int c = 0; c < 200 && nburst < 7; c++) begin
            @(negedge clk);
            if (issued >= 7 * VL)        req_valid = 4'b0000;
            else if (issued >= 3 * VL + 1) req_valid = 4'b1011;
            else                         req_valid = 4'b1001;
            #2;
            if (act_valid_in) begin
                issued++;
                started = 1'b1;
            end else if (started && issued < 7 * VL) begin
                gaps++;
            end
            if (out_valid && out_last) begin
                checks++;
                if (out_id !== 2'(exp_order[nburst])) begin
                    failures++;
                    $display("[TB] FAIL rr_order%0d: got id %0d expected %0d",
                             nburst, out_id, exp_order[nburst]);
                end
                nburst++;
            end
        end
        checks++;
        if (nburst != 7) begin
            failures++;
            $display("[TB] FAIL rr_burst_count: got %0d expected 7", nburst);
        end
        checks++;
        if (gaps != 6) begin
            failures++;
            $display("[TB] FAIL rr_gap_cycles: got %0d expected 6", gaps);
        end
    endtask

    // Requester 1 withdraws for 5 cycles after 8 beats; the burst resumes.
    task automatic test_stall();
        int issued = 0;
        int gap    = 0;
        int nlast  = 0;
        logic [DW-1:0] last_data = '0;
        logic [1:0]    last_id   = '0;
        bit stall;
        do_reset();
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            stall = (issued == 8) && (gap < 5);
            if (issued >= VL || stall) req_valid = 4'b0000;
            else                       req_valid = 4'b0010;
            set_lane(1, 32'(1000 + issued));
            #2;
            if (stall) begin
                gap++;
                checks++;
                if ({act_valid_in, req_ready} !== 5'b0) begin
                    failures++;
                    $display("[TB] FAIL stall_gap%0d: got avi=%b rdy=%b expected 0/0000",
                             gap, act_valid_in, req_ready);
                end
            end
            if (act_valid_in) issued++;
            if (out_valid && out_last) begin
                nlast++;
                last_data = out_data;
                last_id   = out_id;
            end
        end
        checks++;
        if (issued != VL) begin
            failures++;
            $display("[TB] FAIL stall_beats: got %0d expected %0d", issued, VL);
        end
        checks++;
        if ({nlast == 1, last_id, last_data} !== {1'b1, 2'd1, 32'd1015}) begin
            failures++;
            $display("[TB] FAIL stall_last: got count=%0d id=%0d d=%0d expected 1/1/1015",
                     nlast, last_id, last_data);
        end
    endtask

    // Signed data through both ReLU units; tags and latency per instance.
    task automatic test_relu_data();
        logic [DW-1:0] vin [VL] = '{32'hFFFF_FFFB, 32'h0000_0000, 32'h0000_0007, 32'h8000_0000,
                                    32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 32'hFFFF_FFFF,
                                    32'h0000_0064, 32'hFFFF_FF9C, 32'h7FFF_FFFF, 32'h0000_0005,
                                    32'h0000_0006, 32'hFFFF_FFF9, 32'h0000_0008, 32'h0000_0009};
        logic [DW-1:0] vexp [VL] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0007, 32'h0000_0000,
                                     32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 32'h0000_0000,
                                     32'h0000_0064, 32'h0000_0000, 32'h7FFF_FFFF, 32'h0000_0005,
                                     32'h0000_0006, 32'h0000_0000, 32'h0000_0008, 32'h0000_0009};
        int icyc [VL];
        int issued = 0;
        int k1 = 0;
        int k3 = 0;
        do_reset();
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (issued < VL) begin
                req_valid = 4'b1000;
                set_lane(3, vin[issued]);
            end else begin
                req_valid = 4'b0000;
            end
            #2;
            if (act_valid_in && issued < VL) begin
                icyc[issued] = c;
                issued++;
            end
            if (out_valid && k1 < VL) begin
                checks++;
                if ({out_id, out_last, out_data} !== {2'd3, k1 == VL - 1, vexp[k1]}) begin
                    failures++;
                    $display("[TB] FAIL relu_lat1_out%0d: got id=%0d last=%b d=%h expected 3/%b/%h",
                             k1, out_id, out_last, out_data, k1 == VL - 1, vexp[k1]);
                end
                checks++;
                if (c != icyc[k1] + 1) begin
                    failures++;
                    $display("[TB] FAIL relu_lat1_time%0d: got cycle %0d expected %0d", k1, c, icyc[k1] + 1);
                end
                k1++;
            end
            if (ov3 && k3 < VL) begin
                checks++;
                if ({oid3, ol3, od3} !== {2'd3, k3 == VL - 1, vexp[k3]}) begin
                    failures++;
                    $display("[TB] FAIL relu_lat3_out%0d: got id=%0d last=%b d=%h expected 3/%b/%h",
                             k3, oid3, ol3, od3, k3 == VL - 1, vexp[k3]);
                end
                checks++;
                if (c != icyc[k3] + 3) begin
                    failures++;
                    $display("[TB] FAIL relu_lat3_time%0d: got cycle %0d expected %0d", k3, c, icyc[k3] + 3);
                end
                k3++;
            end
        end
        checks++;
        if ({k1 == VL, k3 == VL, tag_err, terr3} !== 4'b1100) begin
            failures++;
            $display("[TB] FAIL relu_counts: got k1=%0d k3=%0d err=%b err3=%b expected 16/16/0/0",
                     k1, k3, tag_err, terr3);
        end
    endtask

    // Reset lands in the middle of requester 3's burst while rr_ptr is 3.
    task automatic test_reset_mid_burst();
        int issued = 0;
        do_reset();
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            req_valid = (issued < VL) ? 4'b0100 : 4'b0000;
            #2;
            if (act_valid_in) issued++;
        end
        issued = 0;
        for (int c = 0; c < 20 && issued < 9; c++) begin
            @(negedge clk);
            req_valid = 4'b1000;
            #2;
            if (act_valid_in) issued++;
        end
        checks++;
        if (issued != 9) begin
            failures++;
            $display("[TB] FAIL midrst_prefix: got %0d beats expected 9", issued);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        checks++;
        if ({req_ready, act_valid_in, busy, out_id, out_last} !== 9'b0) begin
            failures++;
            $display("[TB] FAIL midrst_outputs: got %b expected 0",
                     {req_ready, act_valid_in, busy, out_id, out_last});
        end
        @(negedge clk);
        @(negedge clk);
        rst_n     = 1'b1;
        req_valid = 4'b1010;
        #2;
        checks++;
        if ({req_ready, act_valid_in, busy} !== 6'b0) begin
            failures++;
            $display("[TB] FAIL midrst_arb_cycle: got %b expected 0", {req_ready, act_valid_in, busy});
        end
        @(negedge clk);
        #2;
        checks++;
        if ({req_ready, act_valid_in} !== 5'b0010_1) begin
            failures++;
            $display("[TB] FAIL midrst_regrant: got rdy=%b avi=%b expected 0010/1", req_ready, act_valid_in);
        end
    endtask

    // Spurious result with nothing issued sets the sticky error flag.
    task automatic test_tag_err();
        do_reset();
        @(negedge clk);
        inject = 1'b1;
        #2;
        checks++;
        if (tag_err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL tagerr_before: got %b expected 0", tag_err);
        end
        @(negedge clk);
        inject = 1'b0;
        #2;
        checks++;
        if (tag_err !== 1'b1) begin
            failures++;
            $display("[TB] FAIL tagerr_set: got %b expected 1", tag_err);
        end
        repeat (3) @(negedge clk);
        #2;
        checks++;
        if (tag_err !== 1'b1) begin
            failures++;
            $display("[TB] FAIL tagerr_sticky: got %b expected 1", tag_err);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        checks++;
        if (tag_err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL tagerr_reset: got %b expected 0", tag_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Test sequence.
    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        inject    = 1'b0;
        test_reset();
        test_single_burst();
        test_round_robin();
        test_stall();
        test_relu_data();
        test_reset_mid_burst();
        test_tag_err();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/relu_burst_scheduler.md
# relu_burst_scheduler

- Time-shares one pipelined element-wise activation unit (ReLU-style: 1 valid/data in, 1 valid/data out, fixed latency, no backpressure) among NUM_REQ vector producers.
- Grants whole bursts of VEC_LEN elements round-robin and issues them to the unit one element per cycle.
- Tags each result with requester ID and end-of-vector flag as it emerges.
- Sits between the layer output buffers and the activation stage of the inference pipeline.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (≥2)
- DATA_WIDTH, 32, signed element width
- VEC_LEN, 16, elements per burst (≥2)
- ACT_LATENCY, 1, activation unit latency in cycles (≥1)

Ports (IDW = $clog2(NUM_REQ)):
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  requester i has an element on its data lane
- req_data  in  NUM_REQ*DATA_WIDTH  flattened lanes, lane i = bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_ready  out  NUM_REQ  element on lane i consumed this cycle
- act_valid_in  out  1  to activation unit
- act_data_in  out  DATA_WIDTH  to activation unit, signed
- act_valid_out  in  1  from activation unit
- act_data_out  in  DATA_WIDTH  from activation unit
- out_valid  out  1  result valid
- out_data  out  DATA_WIDTH  result element
- out_id  out  IDW  requester owning result
- out_last  out  1  result is element VEC_LEN-1 of its burst
- busy  out  1  burst in progress or results in flight
- tag_err  out  1  sticky: act_valid_out seen with no matching issued element

## Operation
- FSM states: IDLE, BURST. Registers: owner (IDW), beat_cnt ($clog2(VEC_LEN)), rr_ptr (IDW), tag pipeline of ACT_LATENCY stages {v, id, last}.
- IDLE: if any req_valid, winner = first asserted index searching rr_ptr, rr_ptr+1, … mod NUM_REQ. owner <= winner, beat_cnt <= 0, go BURST. No element is issued in IDLE.
- BURST: fire = req_valid[owner]. req_ready = one-hot(owner) & fire, combinational. act_valid_in = fire. act_data_in = lane[owner], combinational mux.
- On fire: beat_cnt++. If beat_cnt == VEC_LEN-1: rr_ptr <= owner+1 (mod NUM_REQ, wrapping), go IDLE.
- Owner dropping req_valid mid-burst stalls: no issue, beat_cnt held, state held. The grant is never revoked and other requesters wait.
- Tag stage 0 <= {fire, owner, fire & beat_cnt==VEC_LEN-1} every cycle; stage k <= stage k-1.
- Output stage: out_valid = act_valid_out, out_data = act_data_out, out_id/out_last = last tag stage id/last, all combinational pass-through.
- tag_err <= 1 when act_valid_out=1 and last tag stage v=0. Cleared only by reset.
- busy = (state==BURST) | OR of all tag stage v bits.
- Element values are not inspected or modified; sign handling is the activation unit's.

## Timing
- Reset (async assert, sync release): state IDLE, owner 0, beat_cnt 0, rr_ptr 0, all tag stages cleared, tag_err 0.
- Outputs during reset: req_ready 0, act_valid_in 0, busy 0, out_id/out_last 0 when tag stages are clear. In-flight tags are discarded.
- Grant latency: req_valid rising at cycle t in IDLE → first req_ready/act_valid_in at t+1.
- Gap: exactly one idle issue cycle between consecutive bursts (the IDLE arbitration cycle).
- Unstalled burst occupies VEC_LEN consecutive cycles; peak throughput VEC_LEN/(VEC_LEN+1).
- Result for an element issued at cycle t appears with correct out_id/out_last at t+ACT_LATENCY.
- Requester request changes during BURST do not affect the current owner. A requester granted last is lowest priority next arbitration.
- Reset mid-burst aborts the burst. The requester's partial data is its own responsibility.

## Test plan
- Single requester 2, VEC_LEN=16, req_valid held: grant 1 cycle later, 16 consecutive req_ready[2] pulses, 16 outputs with out_id=2, out_last only on 16th, busy low 1 cycle after last output.
- Requesters 0 and 3 both continuously valid from reset: burst order 0,3,0,3…. Next arbitration after 3 with requester 1 added: order 0,1,3.
- Requester 1 drops req_valid for 5 cycles after beat 7: no issue during the gap, beat_cnt holds, 16 total beats, out_last on the 16th with value matching lane input.
- Data check with ReLU unit attached: inputs −5, 0, 7, −2147483648 → outputs 0, 0, 7, 0, each tagged with the correct id; ACT_LATENCY=3 variant gives identical tagging.
- Assert rst_n low at beat 9 of a burst: req_ready/act_valid_in/busy drop immediately, tags cleared. After release, a fresh arbitration starts from rr_ptr=0.
- Inject act_valid_out with no prior issue: tag_err rises next cycle and stays 1 until reset.
